// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into a wait-stated bus transaction,
// stalling the core until done. Optional macro LSU_TIMEOUT_EN adds a bus timeout.
// Ports: clk, reset (async active-low); core_re/we/funct3/addr/wdata in,
//   core_rdata/stall/done/err out; bus_req/we/addr/be/wdata out,
//   bus_ready/rdata in.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_re,
  input  logic        core_we,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic        fault_c;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] lane_w;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign req = core_re | core_we;

  always_comb begin
    fault_c = 1'b0;
    be_c    = 4'b0000;
    wd_c    = 32'h0;
    case (core_funct3)
      3'b000, 3'b100: begin
        be_c = 4'b0001 << core_addr[1:0];
        wd_c = {4{core_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        be_c    = 4'b0011 << {core_addr[1], 1'b0};
        wd_c    = {2{core_wdata[15:0]}};
        fault_c = core_addr[0];
      end
      3'b010: begin
        be_c    = 4'b1111;
        wd_c    = core_wdata;
        fault_c = |core_addr[1:0];
      end
      default: fault_c = 1'b1;
    endcase
  end

  // Lane select uses the offset captured at request time.
  assign lane_w = bus_rdata >> {off_q, 3'b000};
  assign ld_b   = lane_w[7:0];
  assign ld_h   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_ext = {24'h0, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_ext = {16'h0, ld_h};
      default: ld_ext = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Store wins when both request lines are high.
          we_d  = core_we;
          f3_d  = core_funct3;
          off_d = core_addr[1:0];
`ifdef LSU_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (fault_c) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = {core_addr[31:2], 2'b00};
            be_d    = be_c;
            wdata_d = wd_c;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (bus_ready) begin
          if (!we_q) rdata_d = ld_ext;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus_req    = (state_q == S_BUS);
  assign bus_we     = bus_req & we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign core_rdata = rdata_q;
  assign done       = (state_q == S_DONE);
  assign err        = done & err_q;
  assign stall      = bus_req | ((state_q == S_IDLE) & req);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected
// bus and completion records; monitors pop and compare.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_re, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        stall, done, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .core_re(core_re), .core_we(core_we),
    .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .stall(stall), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  done_t dq[$];
  bus_t  bq[$];

  int checks = 0;
  int failures = 0;
  int n_bus = 1;
  logic [31:0] rd_word = 32'h0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Bus slave: ready in the n_bus-th BUS cycle (n_bus=0: never).
  initial begin
    int bcnt;
    bcnt = 0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        bcnt++;
        bus_ready = (bcnt == n_bus);
        bus_rdata = bus_ready ? rd_word : 32'h0;
      end else begin
        bcnt = 0;
        bus_ready = 1'b0;
      end
    end
  end

  // Monitor: compares bus launches and completions against the queues.
  initial begin
    int scnt;
    bit seen;
    done_t d;
    bus_t b;
    scnt = 0;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        scnt = 0;
        seen = 0;
      end else begin
        if (bus_req && !seen) begin
          seen = 1;
          if (bq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_req_unexpected got=1 exp=0");
          end else begin
            b = bq.pop_front();
            chk("bus_addr", bus_addr, b.addr);
            chk("bus_be", {28'h0, bus_be}, {28'h0, b.be});
            chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
            if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
          end
        end
        if (!bus_req) seen = 0;
        if (stall) scnt++;
        if (done) begin
          if (dq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected got=1 exp=0");
          end else begin
            d = dq.pop_front();
            chk("err", {31'h0, err}, {31'h0, d.err});
            chk("core_rdata", core_rdata, d.rdata);
            chk("stall_cycles", scnt, d.stall);
          end
          scnt = 0;
        end else if (err) begin
          checks++;
          failures++;
          $display("FAIL err_without_done got=1 exp=0");
        end
      end
    end
  end

  task automatic access(input logic re, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int nb,
                        input logic [31:0] word, input logic do_bus,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd, input logic eerr,
                        input int estall);
    bit got;
    got = 0;
    if (do_bus)
      bq.push_back('{addr & 32'hFFFF_FFFC, ebe, we, ewd});
    dq.push_back('{erd, eerr, estall});
    n_bus = nb;
    rd_word = word;
    @(posedge clk);
    #1;
    core_re = re;
    core_we = we;
    core_funct3 = f3;
    core_addr = addr;
    core_wdata = wd;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout addr=%h got=0 exp=1", addr);
    end
    @(posedge clk);
    #1;
    core_re = 1'b0;
    core_we = 1'b0;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr,
                    input int nb, input logic [31:0] word,
                    input logic [3:0] ebe, input logic [31:0] erd);
    access(1'b1, 1'b0, f3, addr, 32'h0, nb, word, 1'b1, ebe, 32'h0,
           erd, 1'b0, 1 + nb);
    last_rd = erd;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input int nb,
                    input logic [3:0] ebe, input logic [31:0] ewd);
    access(1'b0, 1'b1, f3, addr, wd, nb, 32'h0, 1'b1, ebe, ewd,
           last_rd, 1'b0, 1 + nb);
  endtask

  task automatic flt(input logic we, input logic [2:0] f3,
                     input logic [31:0] addr);
    access(~we, we, f3, addr, 32'h5555_AAAA, 1, 32'h0, 1'b0, 4'h0,
           32'h0, last_rd, 1'b1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    core_re = 1'b0;
    core_we = 1'b0;
    core_funct3 = 3'b000;
    core_addr = 32'h0;
    core_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_rdata", core_rdata, 32'h0);
    #2;
    reset = 1'b1;

    ld(3'b010, 32'h100, 1, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    ld(3'b000, 32'h103, 1, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    ld(3'b100, 32'h103, 1, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    st(3'b001, 32'h202, 32'h1234_ABCD, 4, 4'b1100, 32'hABCD_ABCD);
    flt(1'b0, 3'b010, 32'h101);
    flt(1'b0, 3'b011, 32'h100);
    ld(3'b001, 32'h106, 2, 32'h8001_7FFF, 4'b1100, 32'hFFFF_8001);
    ld(3'b101, 32'h104, 1, 32'h8001_F00D, 4'b0011, 32'h0000_F00D);
    st(3'b000, 32'h305, 32'h0000_00A5, 2, 4'b0010, 32'hA5A5_A5A5);
    st(3'b010, 32'h400, 32'hCAFE_F00D, 3, 4'b1111, 32'hCAFE_F00D);
    ld(3'b000, 32'h001, 1, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
    ld(3'b100, 32'h102, 1, 32'h00FF_0000, 4'b0100, 32'h0000_00FF);
    flt(1'b0, 3'b001, 32'h003);
    flt(1'b1, 3'b010, 32'h402);
    flt(1'b0, 3'b110, 32'h100);
    flt(1'b1, 3'b111, 32'h100);
    // Both request lines high: store takes priority.
    access(1'b1, 1'b1, 3'b010, 32'h500, 32'h1122_3344, 1, 32'hFFFF_FFFF,
           1'b1, 4'b1111, 32'h1122_3344, last_rd, 1'b0, 2);

`ifdef LSU_TIMEOUT_EN
    access(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 0, 32'h0, 1'b1, 4'b1111,
           32'h0, last_rd, 1'b1, 9);
    ld(3'b010, 32'h704, 1, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
`endif

    // Reset asserted while the bus access is outstanding.
    bq.push_back('{32'h600, 4'b1111, 1'b0, 32'h0});
    n_bus = 0;
    @(posedge clk);
    #1;
    core_re = 1'b1;
    core_funct3 = 3'b010;
    core_addr = 32'h600;
    repeat (3) @(negedge clk);
    chk("pre_rst_bus_req", {31'h0, bus_req}, 32'h1);
    #2;
    reset = 1'b0;
    core_re = 1'b0;
    #1;
    chk("mid_rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_bus_we", {31'h0, bus_we}, 32'h0);
    chk("mid_rst_bus_addr", bus_addr, 32'h0);
    chk("mid_rst_bus_be", {28'h0, bus_be}, 32'h0);
    chk("mid_rst_bus_wdata", bus_wdata, 32'h0);
    chk("mid_rst_rdata", core_rdata, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    last_rd = 32'h0;

    ld(3'b101, 32'h802, 1, 32'hBEEF_0000, 4'b1100, 32'h0000_BEEF);

    repeat (4) @(negedge clk);
    chk("done_queue_empty", dq.size(), 32'h0);
    chk("bus_queue_empty", bq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
